wf_ring_loader: RTL and testbench
=================================

WF_RING_LOADER -- requirements
Module: wf_ring_loader

Interface
REQ-001 SHALL have parameter WF_DEPTH, default 1024, ring depth in 16-bit samples (fixed to 10-bit address).
REQ-002 SHALL have parameter PRELOAD_NUM, default 512, fill level that releases the DSP.
REQ-003 SHALL have ports, clock and reset first:
- i_clk  in  1  sole clock
- i_rst  in  1  synchronous, active-low reset
- i_wf_start  in  1  one-cycle start pulse
- i_wf_stop  in  1  one-cycle stop pulse
- i_wf_data  in  16  sample from PS/DMA
- i_wf_data_valid  in  1  sample valid
- o_wf_data_ready  out  1  sample accepted when valid&ready
- i_wf_read_cnt  in  1  DSP read-strobe GPIO, asynchronous
- o_wf_ram_addr  out  10  DPBRAM write address
- o_wf_ram_din  out  16  DPBRAM write data
- o_wf_ram_ce  out  1  DPBRAM enable
- o_wf_ram_we  out  1  DPBRAM write enable
- o_dsp_wf_mode  out  1  DSP waveform-mode flag
- o_wf_level  out  11  unread samples in ring
- o_wf_full  out  1  level == 1024
- o_wf_empty  out  1  level == 0
- o_wf_underrun  out  1  sticky underrun flag
- o_wf_write_num  out  32  samples written since start
- o_wf_read_num  out  32  DSP reads accepted since start

Function
REQ-004 SHALL use FSM states IDLE, PRELOAD, RUN, DRAIN.
REQ-005 IDLE + i_wf_start: clear pointers, level, counters, underrun; next PRELOAD. Start outside IDLE ignored.
REQ-006 PRELOAD -> RUN when level >= PRELOAD_NUM; PRELOAD + stop -> IDLE.
REQ-007 RUN + stop -> DRAIN; DRAIN -> IDLE when level == 0. Stop in IDLE ignored.
REQ-008 o_dsp_wf_mode SHALL be a register, 1 exactly while state is RUN or DRAIN.
REQ-009 o_wf_data_ready = (state PRELOAD or RUN) and not full, combinational from registered state/level.
REQ-010 On handshake, next cycle: ce=1, we=1, addr=wr_ptr, din=sample; wr_ptr+1 wraps 1023->0; write_num+1. Otherwise ce=0, we=0.
REQ-011 i_wf_read_cnt SHALL pass a 2-FF synchronizer; rising edge on sync output = read event (3rd clock after input rise).
REQ-012 Read event in RUN/DRAIN with level>0: rd_ptr+1 (wrap 1023->0), read_num+1. Read events in IDLE/PRELOAD ignored.
REQ-013 Level: +1 on write only, -1 on accepted read only, unchanged when both in same cycle; never exceeds 1024 or below 0.
REQ-014 Read event in RUN/DRAIN with level==0 = underrun: set o_wf_underrun, rd_ptr/level unchanged.
REQ-015 Counters SHALL wrap 0xFFFFFFFF->0.

Reset
REQ-016 i_rst low at a clock edge: state IDLE, pointers, level, counters, sync FFs zero; all outputs 0 except o_wf_empty=1; applies mid-operation, pending handshake discarded.

Configuration
REQ-017 Macro WF_UNDERRUN_STOP_EN defined: underrun also forces state IDLE next cycle (mode drops to 0). Undefined: underrun only sets flag, FSM unaffected.

Verification
REQ-018 Start, stream 512 samples 0x0000..0x01FF -> 512 RAM writes addr 0..511, din matches; mode=1 cycle after level hits 512.
REQ-019 In RUN, 1024 writes, no reads -> full=1, ready=0, level=1024; 1025th valid not accepted.
REQ-020 Write and read event same cycle at level 600 -> level stays 600, both counters +1; wr_ptr 1023 wraps to 0.
REQ-021 Stop in RUN at level 3, three read pulses -> DRAIN then IDLE, mode=0, empty=1, read_num includes 3.
REQ-022 Read pulse at level 0 in RUN -> underrun=1; with WF_UNDERRUN_STOP_EN state IDLE, else stays RUN.
REQ-023 Reset low during PRELOAD at level 100 -> next cycle all outputs reset values, empty=1, ce=0.

Source files
------------

// File: rtl/wf_ring_loader.sv
// rtl/wf_ring_loader.sv - waveform ring write-side loader with DSP read tracking (optional WF_UNDERRUN_STOP_EN)
module wf_ring_loader #(
    parameter int WF_DEPTH    = 1024,
    parameter int PRELOAD_NUM = 512
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wf_start,
    input  logic        i_wf_stop,
    input  logic [15:0] i_wf_data,
    input  logic        i_wf_data_valid,
    output logic        o_wf_data_ready,
    input  logic        i_wf_read_cnt,
    output logic [9:0]  o_wf_ram_addr,
    output logic [15:0] o_wf_ram_din,
    output logic        o_wf_ram_ce,
    output logic        o_wf_ram_we,
    output logic        o_dsp_wf_mode,
    output logic [10:0] o_wf_level,
    output logic        o_wf_full,
    output logic        o_wf_empty,
    output logic        o_wf_underrun,
    output logic [31:0] o_wf_write_num,
    output logic [31:0] o_wf_read_num
);

    localparam int AW = 10;
    localparam int LW = 11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRELOAD = 2'd1,
        ST_RUN     = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic [31:0]    write_num_q, write_num_d;
    logic [31:0]    read_num_q, read_num_d;
    logic           underrun_q, underrun_d;
    logic           mode_q, mode_d;
    logic           ram_ce_q, ram_ce_d;
    logic           ram_we_q, ram_we_d;
    logic [AW-1:0]  ram_addr_q, ram_addr_d;
    logic [15:0]    ram_din_q, ram_din_d;
    // [0],[1] form the synchronizer; [2] is the previous synchronized value for edge detect
    logic [2:0]     rd_sync_q, rd_sync_d;

    logic full;
    logic empty;
    logic ready;
    logic active;
    logic wr_fire;
    logic rd_evt;
    logic rd_accept;
    logic underrun_evt;
    logic start_clear;

    assign full         = (level_q == LW'(WF_DEPTH));
    assign empty        = (level_q == '0);
    assign active       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign wr_fire      = i_wf_data_valid && ready;
    assign rd_evt       = rd_sync_q[1] && !rd_sync_q[2];
    assign rd_accept    = rd_evt && active && !empty;
    assign underrun_evt = rd_evt && active && empty;
    assign start_clear  = (state_q == ST_IDLE) && i_wf_start;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an underrun optionally aborts the session
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_wf_start) state_d = ST_PRELOAD;
            end
            ST_PRELOAD: begin
                if (i_wf_stop) state_d = ST_IDLE;
                else if (level_q >= LW'(PRELOAD_NUM)) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (i_wf_stop) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (empty) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef WF_UNDERRUN_STOP_EN
        if (underrun_evt) state_d = ST_IDLE;
`else
`endif
    end

    // FSM outputs: accept samples while loading and not full; DSP mode tracks RUN/DRAIN
    always_comb begin
        ready  = ((state_q == ST_PRELOAD) || (state_q == ST_RUN)) && !full;
        mode_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    end

    // Datapath next values: RAM write port, pointers, fill level, counters, read sync
    always_comb begin
        rd_sync_d   = {rd_sync_q[1:0], i_wf_read_cnt};
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        write_num_d = write_num_q;
        read_num_d  = read_num_q;
        underrun_d  = underrun_q;
        ram_ce_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        if (start_clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            write_num_d = '0;
            read_num_d  = '0;
            underrun_d  = 1'b0;
        end else begin
            if (wr_fire) begin
                ram_ce_d    = 1'b1;
                ram_we_d    = 1'b1;
                ram_addr_d  = wr_ptr_q;
                ram_din_d   = i_wf_data;
                wr_ptr_d    = (wr_ptr_q == AW'(WF_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
                write_num_d = write_num_q + 32'd1;
            end
            if (rd_accept) begin
                rd_ptr_d   = (rd_ptr_q == AW'(WF_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
                read_num_d = read_num_q + 32'd1;
            end
            if (wr_fire && !rd_accept) begin
                level_d = level_q + 1'b1;
            end else if (rd_accept && !wr_fire) begin
                level_d = level_q - 1'b1;
            end
            if (underrun_evt) underrun_d = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            rd_sync_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            write_num_q <= '0;
            read_num_q  <= '0;
            underrun_q  <= 1'b0;
            mode_q      <= 1'b0;
            ram_ce_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
        end else begin
            rd_sync_q   <= rd_sync_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            write_num_q <= write_num_d;
            read_num_q  <= read_num_d;
            underrun_q  <= underrun_d;
            mode_q      <= mode_d;
            ram_ce_q    <= ram_ce_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
        end
    end

    assign o_wf_data_ready = ready;
    assign o_wf_ram_addr   = ram_addr_q;
    assign o_wf_ram_din    = ram_din_q;
    assign o_wf_ram_ce     = ram_ce_q;
    assign o_wf_ram_we     = ram_we_q;
    assign o_dsp_wf_mode   = mode_q;
    assign o_wf_level      = level_q;
    assign o_wf_full       = full;
    assign o_wf_empty      = empty;
    assign o_wf_underrun   = underrun_q;
    assign o_wf_write_num  = write_num_q;
    assign o_wf_read_num   = read_num_q;

endmodule

// File: tb/tb_wf_ring_loader.sv
// tb/tb_wf_ring_loader.sv - scoreboard testbench for wf_ring_loader
module tb_wf_ring_loader;

    localparam int DEPTH = 1024;
    localparam int PRE   = 512;
    localparam int S_IDLE = 0, S_PRE = 1, S_RUN = 2, S_DRAIN = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, stop, valid, rd;
    logic [15:0] data;
    logic        ready, ce, we, mode, full, empty, under;
    logic [9:0]  addr;
    logic [15:0] din;
    logic [10:0] level;
    logic [31:0] wnum, rnum;

    wf_ring_loader #(.WF_DEPTH(DEPTH), .PRELOAD_NUM(PRE)) dut (
        .i_clk(clk), .i_rst(rst), .i_wf_start(start), .i_wf_stop(stop),
        .i_wf_data(data), .i_wf_data_valid(valid), .o_wf_data_ready(ready),
        .i_wf_read_cnt(rd), .o_wf_ram_addr(addr), .o_wf_ram_din(din),
        .o_wf_ram_ce(ce), .o_wf_ram_we(we), .o_dsp_wf_mode(mode),
        .o_wf_level(level), .o_wf_full(full), .o_wf_empty(empty),
        .o_wf_underrun(under), .o_wf_write_num(wnum), .o_wf_read_num(rnum)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int          m_state = S_IDLE;
    int          m_level = 0;
    int          m_wrp   = 0;
    int unsigned m_wn    = 0;
    int unsigned m_rn    = 0;
    bit          m_under = 0;
    bit          h1 = 0, h2 = 0, h3 = 0;
    int          exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return (m_state == S_PRE || m_state == S_RUN) && (m_level < DEPTH);
    endfunction

    // Advances the model by one clock edge with the given inputs
    function automatic void model_step(bit r, bit st, bit sp, bit v, logic [15:0] d, bit rc);
        bit evt, act, wr, rdok, ur;
        int old_level;
        if (!r) begin
            m_state = S_IDLE; m_level = 0; m_wrp = 0; m_wn = 0; m_rn = 0; m_under = 0;
            h1 = 0; h2 = 0; h3 = 0;
            return;
        end
        evt = h2 && !h3;
        h3 = h2; h2 = h1; h1 = rc;
        act  = (m_state == S_RUN || m_state == S_DRAIN);
        wr   = v && m_ready();
        rdok = evt && act && m_level > 0;
        ur   = evt && act && m_level == 0;
        old_level = m_level;
        if (wr) begin
            exp_q.push_back((m_wrp << 16) | int'(d));
            m_wrp = (m_wrp + 1) % DEPTH;
            m_wn++;
        end
        if (rdok) m_rn++;
        m_level = m_level + int'(wr) - int'(rdok);
        if (ur) m_under = 1;
        case (m_state)
            S_IDLE: if (st) begin
                m_state = S_PRE; m_level = 0; m_wrp = 0; m_wn = 0; m_rn = 0; m_under = 0;
            end
            S_PRE:   if (sp) m_state = S_IDLE; else if (old_level >= PRE) m_state = S_RUN;
            S_RUN:   if (sp) m_state = S_DRAIN;
            default: if (old_level == 0) m_state = S_IDLE;
        endcase
`ifdef WF_UNDERRUN_STOP_EN
        if (ur) m_state = S_IDLE;
`endif
    endfunction

    // One clock: drive at negedge, step model, check status after the edge
    task automatic cyc(input bit r, input bit st, input bit sp, input bit v, input logic [15:0] d, input bit rc);
        rst = r; start = st; stop = sp; valid = v; data = d; rd = rc;
        model_step(r, st, sp, v, d, rc);
        @(posedge clk); #1;
        chk("ready", ready, m_ready());
        chk("mode", mode, (m_state == S_RUN || m_state == S_DRAIN));
        chk("level", level, m_level);
        chk("full", full, m_level == DEPTH);
        chk("empty", empty, m_level == 0);
        chk("underrun", under, m_under);
        chk("write_num", wnum, m_wn);
        chk("read_num", rnum, m_rn);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1, 0, 0, 0, 16'h0, 0);
    endtask

    task automatic rd_pulse(input int n);
        repeat (n) begin
            cyc(1, 0, 0, 0, 16'h0, 1);
            cyc(1, 0, 0, 0, 16'h0, 1);
            cyc(1, 0, 0, 0, 16'h0, 0);
            cyc(1, 0, 0, 0, 16'h0, 0);
        end
    endtask

    task automatic drain_all();
        int g = 0;
        while (m_level > 0 && g < 1100) begin
            rd_pulse(1);
            g++;
        end
        chk("drain_bound", g < 1100, 1);
    endtask

    // Scoreboard monitor: every RAM write must match the oldest expected write
    initial begin
        int e;
        forever begin
            @(posedge clk); #1;
            if (ce || we) begin
                if (exp_q.size() == 0) begin
                    chk("ram_unexpected_write", {ce, we}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    chk("ram_addr", addr, e >> 16);
                    chk("ram_din", din, e & 16'hFFFF);
                    chk("ram_ce_we", {ce, we}, 2'b11);
                end
            end
        end
    end

    initial begin
        rst = 0; start = 0; stop = 0; valid = 0; data = 0; rd = 0;
        @(negedge clk);
        repeat (3) cyc(0, 0, 0, 0, 16'h0, 0);
        chk("reset_ce", ce, 0);

        // Preload ramp 0x0000..0x01FF, then release into RUN
        cyc(1, 1, 0, 0, 16'h0, 0);
        for (int i = 0; i < PRE; i++) cyc(1, 0, 0, 1, 16'(i), 0);
        idle(2);
        chk("preload_mode", mode, 1);

        // Fill to full with valid held beyond capacity
        for (int i = 0; i < 600; i++) cyc(1, 0, 0, 1, 16'($urandom), 0);
        chk("full_flag", full, 1);
        chk("full_ready", ready, 0);

        // Read down to 600, then mixed concurrent traffic across the pointer wrap
        rd_pulse(424);
        for (int i = 0; i < 2500; i++)
            cyc(1, 0, 0, ($urandom % 3) == 0, 16'($urandom), 1'($urandom));

        // Stop, drain to empty, then reads in IDLE are ignored
        cyc(1, 0, 1, 0, 16'h0, 0);
        drain_all();
        idle(3);
        chk("drain_idle_mode", mode, 0);
        chk("drain_empty", empty, 1);
        rd_pulse(2);

        // Underrun: preload, read everything, one extra pulse
        cyc(1, 1, 0, 0, 16'h0, 0);
        for (int i = 0; i < PRE; i++) cyc(1, 0, 0, 1, 16'($urandom), 0);
        idle(2);
        drain_all();
        rd_pulse(1);
        chk("underrun_flag", under, 1);
`ifdef WF_UNDERRUN_STOP_EN
        chk("underrun_mode", mode, 0);
`else
        chk("underrun_mode", mode, 1);
`endif
        cyc(1, 0, 1, 0, 16'h0, 0);
        idle(3);

        // Reset mid-PRELOAD at level 100
        cyc(1, 1, 0, 0, 16'h0, 0);
        for (int i = 0; i < 100; i++) cyc(1, 0, 0, 1, 16'($urandom), 0);
        cyc(0, 0, 0, 1, 16'h1234, 0);
        chk("rst_level", level, 0);
        chk("rst_ce", ce, 0);
        chk("rst_empty", empty, 1);

        // Random control traffic
        for (int i = 0; i < 5000; i++)
            cyc(($urandom % 700) != 0, ($urandom % 40) == 0, ($urandom % 300) == 0,
                ($urandom % 2) == 0, 16'($urandom), 1'($urandom));

        idle(4);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
